// File: rtl/multi_edge_detect_if.sv
// Channel bus for multi_edge_detect: raw inputs and controls in, pulses and status out.
interface multi_edge_detect_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0]   sig_i;
  logic [2*WIDTH-1:0] mode_i;
  logic [WIDTH-1:0]   clear_i;
  logic [WIDTH-1:0]   irq_mask_i;
  logic [WIDTH-1:0]   pulse_o;
  logic [WIDTH-1:0]   level_o;
  logic [WIDTH-1:0]   event_o;
  logic               irq_o;

  // Side that drives the channels and consumes status (IO / interrupt logic).
  modport master (
    output sig_i, mode_i, clear_i, irq_mask_i,
    input  pulse_o, level_o, event_o, irq_o
  );

  // The edge detector itself.
  modport slave (
    input  sig_i, mode_i, clear_i, irq_mask_i,
    output pulse_o, level_o, event_o, irq_o
  );
endinterface

// File: rtl/multi_edge_detect.sv
// Multi-channel synchronising edge detector with per-channel mode, hold-off
// lockout, sticky event flags and a masked interrupt request.
module multi_edge_detect #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int HOLDOFF     = 0
) (
  input logic                clk,
  input logic                reset_n,
  multi_edge_detect_if.slave bus
);

  // Hold-off counter is at least one bit wide so HOLDOFF=0 still elaborates.
  localparam int            CW        = (HOLDOFF < 1) ? 1 : $clog2(HOLDOFF + 1);
  localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLDOFF);

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] sync_d [SYNC_STAGES];
  logic [WIDTH-1:0] hist_q,  hist_d;
  logic [WIDTH-1:0] pulse_q, pulse_d;
  logic [WIDTH-1:0] event_q, event_d;
  logic [CW-1:0]    hold_q [WIDTH];
  logic [CW-1:0]    hold_d [WIDTH];
  logic [WIDTH-1:0] rise, fall, hit;

  // Input pipeline: shift raw inputs through the synchroniser, history follows last stage.
  always_comb begin
    sync_d[0] = bus.sig_i;
    for (int k = 1; k < SYNC_STAGES; k++) begin
      sync_d[k] = sync_q[k-1];
    end
    // History tracks the synchronised level in every mode, so switching mode
    // never manufactures an edge out of a stale history bit.
    hist_d = sync_q[SYNC_STAGES-1];
  end

  // Edge detection, hold-off lockout and sticky event next-state per channel.
  always_comb begin
    // NOTE: every output of a combinational block gets a default before any
    // conditional assignment; a path that leaves one unassigned infers a latch.
    rise    = '0;
    fall    = '0;
    hit     = '0;
    pulse_d = '0;
    event_d = event_q;
    for (int i = 0; i < WIDTH; i++) begin
      hold_d[i] = hold_q[i];
    end

    for (int i = 0; i < WIDTH; i++) begin
      rise[i] = sync_q[SYNC_STAGES-1][i] & ~hist_q[i];
      fall[i] = ~sync_q[SYNC_STAGES-1][i] & hist_q[i];
      // An edge seen while the lockout runs is dropped, never deferred.
      hit[i]  = ((bus.mode_i[2*i] & rise[i]) | (bus.mode_i[2*i+1] & fall[i]))
                & (hold_q[i] == '0);

      pulse_d[i] = hit[i];

      // Lockout runs down in every mode, including off.
      if (HOLDOFF == 0) begin
        hold_d[i] = '0;
      end else if (hit[i]) begin
        hold_d[i] = HOLD_LOAD;
      end else if (hold_q[i] != '0) begin
        hold_d[i] = hold_q[i] - CW'(1);
      end

      // A new event beats a same-cycle clear so no edge is ever lost to software.
      if (hit[i]) begin
        event_d[i] = 1'b1;
      end else if (bus.clear_i[i]) begin
        event_d[i] = 1'b0;
      end
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: the synchroniser and hold-off counters are flop arrays, not a
      // memory, so they are reset like any other register; a stale hold-off
      // count would otherwise swallow the first edge after reset.
      for (int k = 0; k < SYNC_STAGES; k++) begin
        sync_q[k] <= '0;
      end
      for (int i = 0; i < WIDTH; i++) begin
        hold_q[i] <= '0;
      end
      hist_q  <= '0;
      pulse_q <= '0;
      event_q <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignment so every flop
      // samples the pre-edge values regardless of statement order.
      for (int k = 0; k < SYNC_STAGES; k++) begin
        sync_q[k] <= sync_d[k];
      end
      for (int i = 0; i < WIDTH; i++) begin
        hold_q[i] <= hold_d[i];
      end
      hist_q  <= hist_d;
      pulse_q <= pulse_d;
      event_q <= event_d;
    end
  end

  assign bus.pulse_o = pulse_q;
  assign bus.level_o = sync_q[SYNC_STAGES-1];
  assign bus.event_o = event_q;
  // Interrupt follows the mask combinationally; masking never clears a flag.
  assign bus.irq_o   = |(event_q & bus.irq_mask_i);

endmodule

// File: tb/tb_multi_edge_detect.sv
// Self-checking bench: two instances (no lockout, 4-cycle lockout) fed the same
// directed stimulus, checked every cycle against an edge-timeline model plus
// hand-computed expectations.
module tb_multi_edge_detect;
  localparam int W = 8;
  localparam int N = 2;

  logic           clk     = 1'b0;
  logic           reset_n = 1'b1;
  logic [W-1:0]   sig     = '0;
  logic [2*W-1:0] mode    = '0;
  logic [W-1:0]   clr     = '0;
  logic [W-1:0]   mask    = '0;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  multi_edge_detect_if #(.WIDTH(W)) if_a ();
  multi_edge_detect_if #(.WIDTH(W)) if_b ();

  assign if_a.sig_i      = sig;
  assign if_a.mode_i     = mode;
  assign if_a.clear_i    = clr;
  assign if_a.irq_mask_i = mask;
  assign if_b.sig_i      = sig;
  assign if_b.mode_i     = mode;
  assign if_b.clear_i    = clr;
  assign if_b.irq_mask_i = mask;

  multi_edge_detect #(.WIDTH(W), .SYNC_STAGES(N), .HOLDOFF(0)) dut_a (
    .clk(clk), .reset_n(reset_n), .bus(if_a.slave)
  );
  multi_edge_detect #(.WIDTH(W), .SYNC_STAGES(N), .HOLDOFF(4)) dut_b (
    .clk(clk), .reset_n(reset_n), .bus(if_b.slave)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int hold_of(input int inst);
    return (inst == 0) ? 0 : 4;
  endfunction

  // ---------------- model: sample timeline and time since last report ----------------
  // dl[ch][0] is the newest sample taken; dl[ch][N-1] is the level the channel
  // sees now and dl[ch][N] the level one clock earlier.
  bit         dl [W][N+1];
  logic [W-1:0] exp_pulse [2];
  logic [W-1:0] exp_event [2];
  logic [W-1:0] exp_level;
  int         last_hit [2][W];
  int         edge_no = 0;
  bit         m_cur, m_prv, m_want, m_hit;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int ch = 0; ch < W; ch++)
        for (int k = 0; k <= N; k++) dl[ch][k] = 1'b0;
      exp_level = '0;
      for (int inst = 0; inst < 2; inst++) begin
        exp_pulse[inst] = '0;
        exp_event[inst] = '0;
        for (int ch = 0; ch < W; ch++) last_hit[inst][ch] = -1000;
      end
    end else begin
      edge_no++;
      for (int inst = 0; inst < 2; inst++) begin
        for (int ch = 0; ch < W; ch++) begin
          m_cur  = dl[ch][N-1];
          m_prv  = dl[ch][N];
          m_want = (mode[2*ch] && m_cur && !m_prv) || (mode[2*ch+1] && !m_cur && m_prv);
          m_hit  = m_want && ((edge_no - last_hit[inst][ch]) > hold_of(inst));
          if (m_hit) last_hit[inst][ch] = edge_no;
          exp_pulse[inst][ch] = m_hit;
          if (m_hit) exp_event[inst][ch] = 1'b1;
          else if (clr[ch]) exp_event[inst][ch] = 1'b0;
        end
      end
      for (int ch = 0; ch < W; ch++) begin
        for (int k = N; k > 0; k--) dl[ch][k] = dl[ch][k-1];
        dl[ch][0] = sig[ch];
        exp_level[ch] = dl[ch][N-1];
      end
    end
  end

  // ---------------- every-cycle compare against the model ----------------
  always @(negedge clk) begin
    check("a_pulse", if_a.pulse_o, exp_pulse[0]);
    check("a_event", if_a.event_o, exp_event[0]);
    check("a_level", if_a.level_o, exp_level);
    check("a_irq",   if_a.irq_o,   |(exp_event[0] & mask));
    check("b_pulse", if_b.pulse_o, exp_pulse[1]);
    check("b_event", if_b.event_o, exp_event[1]);
    check("b_level", if_b.level_o, exp_level);
    check("b_irq",   if_b.irq_o,   |(exp_event[1] & mask));
  end

  // ---------------- pulse counters and lockout spacing ----------------
  int cnt_a [W];
  int cnt_b [W];
  int last_b [W];
  int cyc = 0;

  initial begin
    for (int ch = 0; ch < W; ch++) begin
      cnt_a[ch]  = 0;
      cnt_b[ch]  = 0;
      last_b[ch] = -100;
    end
  end

  always @(negedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int ch = 0; ch < W; ch++) last_b[ch] = -100;
    end else begin
      cyc++;
      for (int ch = 0; ch < W; ch++) begin
        if (if_a.pulse_o[ch]) cnt_a[ch]++;
        if (if_b.pulse_o[ch]) begin
          cnt_b[ch]++;
          check("b_holdoff_gap", 32'((cyc - last_b[ch]) > 4), 32'd1);
          last_b[ch] = cyc;
        end
      end
    end
  end

  // Advance n rising edges; inputs change 2 time units after the edge.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  int base_a [W];
  int base_b [W];
  task automatic snap();
    for (int ch = 0; ch < W; ch++) begin
      base_a[ch] = cnt_a[ch];
      base_b[ch] = cnt_b[ch];
    end
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    #1 reset_n = 1'b0;
    mode[1:0] = 2'b01;
    mask      = 8'h01;
    sig[0]    = 1'b1;
    tick(3);
    check("rst_pulse", if_a.pulse_o, 0);
    check("rst_event", if_a.event_o, 0);
    check("rst_level", if_a.level_o, 0);
    check("rst_irq",   if_a.irq_o,   0);

    // Rise timing: input high before edge 1, pulse after edge 3 only.
    sig[0]  = 1'b0;
    reset_n = 1'b1;
    sig[0]  = 1'b1;
    tick(2);
    check("rise_e2_pulse", if_a.pulse_o[0], 0);
    check("rise_e2_level", if_a.level_o[0], 1);
    tick(1);
    check("rise_e3_pulse", if_a.pulse_o[0], 1);
    check("rise_e3_event", if_a.event_o[0], 1);
    check("rise_e3_irq",   if_a.irq_o,      1);
    tick(1);
    check("rise_e4_pulse", if_a.pulse_o[0], 0);
    check("rise_e4_event", if_a.event_o[0], 1);
    mask = 8'h00;
    #1;
    check("mask_irq_now",  if_a.irq_o,      0);
    check("mask_keeps_ev", if_a.event_o[0], 1);
    mask = 8'hFF;

    // Mode coverage: ch1 fall, ch2 both, ch3 off, 6-cycle levels.
    mode[3:2] = 2'b10;
    mode[5:4] = 2'b11;
    mode[7:6] = 2'b00;
    snap();
    sig[3:1] = 3'b111;
    tick(6);
    check("ch1_no_rise", cnt_a[1] - base_a[1], 0);
    check("ch2_rise",    cnt_a[2] - base_a[2], 1);
    sig[3:1] = 3'b000;
    tick(6);
    check("ch1_fall_only", cnt_a[1] - base_a[1], 1);
    check("ch2_both",      cnt_a[2] - base_a[2], 2);
    check("ch3_off",       cnt_a[3] - base_a[3], 0);
    check("ch3_no_event",  if_a.event_o[3],      0);
    check("b_ch2_both",    cnt_b[2] - base_b[2], 2);

    // Hold-off: toggle ch0 every 2 cycles in mode both; lockout keeps every third.
    mode[1:0] = 2'b11;
    snap();
    for (int t = 0; t < 12; t++) begin
      sig[0] = ~sig[0];
      tick(2);
    end
    tick(6);
    check("a_toggle_cnt", cnt_a[0] - base_a[0], 12);
    check("b_holdoff_cnt", cnt_b[0] - base_b[0], 4);

    // Sticky clear collision: clear during the hit cycle loses to the set.
    mode[1:0] = 2'b01;
    sig[0] = 1'b0;
    tick(4);
    clr = 8'hFF;
    tick(1);
    clr = 8'h00;
    check("clr_all_event", if_a.event_o, 0);
    check("clr_all_irq",   if_a.irq_o,   0);
    sig[0] = 1'b1;
    tick(2);
    clr[0] = 1'b1;
    tick(1);
    check("coll_pulse", if_a.pulse_o[0], 1);
    check("coll_event", if_a.event_o[0], 1);
    tick(1);
    check("clr_event", if_a.event_o[0], 0);
    check("clr_irq",   if_a.irq_o,      0);
    clr[0] = 1'b0;

    // Reset mid-operation while pulsing with the lockout counter loaded.
    sig[0] = 1'b0;
    tick(4);
    sig[0] = 1'b1;
    tick(3);
    check("pre_rst_b_pulse", if_b.pulse_o[0], 1);
    check("pre_rst_b_irq",   if_b.irq_o,      1);
    #1 reset_n = 1'b0;
    #1;
    check("async_b_pulse", if_b.pulse_o, 0);
    check("async_b_event", if_b.event_o, 0);
    check("async_b_irq",   if_b.irq_o,   0);
    check("async_a_pulse", if_a.pulse_o, 0);
    tick(1);
    reset_n = 1'b1;
    tick(2);
    check("rel_e2_b_pulse", if_b.pulse_o[0], 0);
    tick(1);
    check("rel_e3_b_pulse", if_b.pulse_o[0], 1);
    check("rel_e3_a_pulse", if_a.pulse_o[0], 1);

    // Mode change on a long-held high input must not report an edge.
    mode[9:8] = 2'b00;
    sig[4] = 1'b1;
    tick(10);
    mode[9:8] = 2'b01;
    snap();
    tick(5);
    check("modechg_no_pulse", cnt_a[4] - base_a[4], 0);
    sig[4] = 1'b0;
    tick(4);
    sig[4] = 1'b1;
    tick(5);
    check("modechg_real_rise", cnt_a[4] - base_a[4], 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish by %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
